// File: rtl/udp_tx_fifo_pkg.sv
// udp_tx_fifo_pkg: shared defaults and the payload word type for the UDP
// transmit FIFO.
//   ADDR_WIDTH_DEF       - log2 of FIFO depth
//   DATA_WIDTH_DEF       - payload word width
//   ALMOST_FULL_NUM_DEF  - almost_full threshold in words
//   ALMOST_EMPTY_NUM_DEF - almost_empty threshold in words
package udp_tx_fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEF       = 7;
  localparam int unsigned DATA_WIDTH_DEF       = 8;
  localparam int unsigned ALMOST_FULL_NUM_DEF  = 43;
  localparam int unsigned ALMOST_EMPTY_NUM_DEF = 4;

  typedef logic [DATA_WIDTH_DEF-1:0] data_word_t;

endpackage

// File: rtl/udp_tx_fifo_ram.sv
// udp_tx_fifo_ram: simple dual-port 2^ADDR_WIDTH x DATA_WIDTH storage with a
// synchronous write port and a registered read port.
// Ports:
//   clk_tb  - clock (rising edge)
//   tb_rst  - async active-high reset, clears only the read register
//   wr_en   - write strobe, wr_addr / wr_data
//   rd_en   - read strobe, rd_addr; rd_data holds when rd_en is low
import udp_tx_fifo_pkg::*;

module udp_tx_fifo_ram #(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_tb,
  input  logic                  tb_rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Storage array: no reset, contents are don't-care until written.
  always_ff @(posedge clk_tb) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register only loads on a read so the last word is held.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/udp_tx_fifo.sv
// udp_tx_fifo: single-clock 2^ADDR_WIDTH x DATA_WIDTH FIFO between the UDP
// packet builder (writer) and the MAC transmit stage (reader).
// Ports:
//   clk_tb, tb_rst (async, active-high)
//   wr_data, wr_en          - write side; writes while full are dropped
//   full, almost_full       - registered, count == depth / count >= ALMOST_FULL_NUM
//   rd_en, rd_data          - read side; reads while empty are dropped
//   empty, almost_empty     - registered, count == 0 / count <= ALMOST_EMPTY_NUM
// Optional (UDP_TX_FIFO_WATER_LEVEL_EN defined):
//   wr_water_level, rd_water_level - registered word count
import udp_tx_fifo_pkg::*;

module udp_tx_fifo #(
  parameter int unsigned ADDR_WIDTH       = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int unsigned OUT_REG          = 1,
  parameter int unsigned ALMOST_FULL_NUM  = ALMOST_FULL_NUM_DEF,
  parameter int unsigned ALMOST_EMPTY_NUM = ALMOST_EMPTY_NUM_DEF
) (
  input  logic                  clk_tb,
  input  logic                  tb_rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty
`ifdef UDP_TX_FIFO_WATER_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   wr_water_level,
  output logic [ADDR_WIDTH:0]   rd_water_level
`endif
);

  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          full_q,         full_d;
  logic          empty_q,        empty_d;
  logic          almost_full_q,  almost_full_d;
  logic          almost_empty_q, almost_empty_d;
  logic          wr_acc_c;
  logic          rd_acc_c;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Acceptance uses the pre-edge flags, so a same-cycle read never frees
  // room for a write while full (and vice versa while empty).
  always_comb begin
    wr_acc_c = wr_en && !full_q;
    rd_acc_c = rd_en && !empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc_c) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
    if (rd_acc_c) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end

    count_d = count_q + CW'(wr_acc_c) - CW'(rd_acc_c);

    full_d         = (count_d == CW'(DEPTH));
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= CW'(ALMOST_FULL_NUM));
    almost_empty_d = (count_d <= CW'(ALMOST_EMPTY_NUM));
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

`ifdef UDP_TX_FIFO_WATER_LEVEL_EN
  // count_q is already a flop, so both levels are registered views of it.
  assign wr_water_level = count_q;
  assign rd_water_level = count_q;
`endif

  udp_tx_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_tb  (clk_tb),
    .tb_rst  (tb_rst),
    .wr_en   (wr_acc_c),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc_c),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  // Optional output stage; the RAM read register already holds between
  // reads, so copying it every cycle keeps rd_data stable too.
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    always_comb begin
      rd_data_d = ram_rd_data;
    end

    always_ff @(posedge clk_tb or posedge tb_rst) begin
      if (tb_rst) begin
        rd_data_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
      end
    end

    assign rd_data = rd_data_q;
  end else begin : g_no_out_reg
    assign rd_data = ram_rd_data;
  end

endmodule

// File: tb/tb_udp_tx_fifo.sv
// tb_udp_tx_fifo: self-checking bench for udp_tx_fifo (default OUT_REG = 1).
// A queue holds the words the FIFO should contain; a popped word is expected
// on rd_data one edge after its accepting read edge.
// Optional: UDP_TX_FIFO_WATER_LEVEL_EN connects and checks the water levels.
module tb_udp_tx_fifo;
  import udp_tx_fifo_pkg::*;

  logic       clk_tb;
  logic       tb_rst;
  data_word_t wr_data;
  logic       wr_en;
  logic       full;
  logic       almost_full;
  logic       rd_en;
  data_word_t rd_data;
  logic       empty;
  logic       almost_empty;
`ifdef UDP_TX_FIFO_WATER_LEVEL_EN
  logic [7:0] wr_water_level;
  logic [7:0] rd_water_level;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  data_word_t sb_q[$];
  data_word_t exp_rd   = '0;
  data_word_t pend_val = '0;
  logic       pend_vld = 1'b0;

  udp_tx_fifo dut (
    .clk_tb       (clk_tb),
    .tb_rst       (tb_rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_empty (almost_empty)
`ifdef UDP_TX_FIFO_WATER_LEVEL_EN
    ,
    .wr_water_level (wr_water_level),
    .rd_water_level (rd_water_level)
`endif
  );

  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs against the queue occupancy and the expected rd_data.
  task automatic check_state(input string tag);
    int unsigned cnt;
    cnt = sb_q.size();
    check({tag, " empty"},        32'(empty),        32'(cnt == 0));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 4));
    check({tag, " almost_full"},  32'(almost_full),  32'(cnt >= 43));
    check({tag, " full"},         32'(full),         32'(cnt == 128));
    check({tag, " rd_data"},      32'(rd_data),      32'(exp_rd));
`ifdef UDP_TX_FIFO_WATER_LEVEL_EN
    check({tag, " wr_water_level"}, 32'(wr_water_level), cnt);
    check({tag, " rd_water_level"}, 32'(rd_water_level), cnt);
`endif
  endtask

  // One clock of traffic; inputs applied 1 time unit after the rising edge.
  task automatic step(input string tag, input logic we, input data_word_t wd, input logic re);
    logic wacc;
    logic racc;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    wacc = we && (sb_q.size() < 128);
    racc = re && (sb_q.size() > 0);
    @(posedge clk_tb);
    #1;
    if (pend_vld) exp_rd = pend_val;
    pend_vld = racc;
    if (racc) pend_val = sb_q.pop_front();
    if (wacc) sb_q.push_back(wd);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    tb_rst = 1'b1;
    #1;
    sb_q.delete();
    exp_rd   = '0;
    pend_vld = 1'b0;
    check_state(tag);
    @(posedge clk_tb);
    #1;
    tb_rst = 1'b0;
    check_state({tag, " released"});
  endtask

  initial begin
    tb_rst  = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    repeat (2) @(posedge clk_tb);
    #1;
    check_state("reset");
    tb_rst = 1'b0;

    // Fill 0..127, then a rejected write while full.
    for (int i = 0; i < 128; i++) step("fill", 1'b1, data_word_t'(i), 1'b0);
    step("overflow", 1'b1, 8'hAA, 1'b0);

    // Drain and flush the last word through the output register.
    for (int i = 0; i < 128; i++) step("drain", 1'b0, '0, 1'b1);
    step("drain tail", 1'b0, '0, 1'b0);
    check("drained word", 32'(rd_data), 32'd127);

    // Reads while empty leave rd_data alone; read+write while empty only writes.
    step("underflow", 1'b0, '0, 1'b1);
    step("underflow", 1'b0, '0, 1'b1);
    step("empty rw", 1'b1, 8'h33, 1'b1);
    step("empty rw read", 1'b0, '0, 1'b1);
    step("empty rw tail", 1'b0, '0, 1'b0);
    check("empty rw word", 32'(rd_data), 32'h33);

    // Simultaneous traffic at count 10.
    for (int i = 0; i < 10; i++) step("pre10", 1'b1, data_word_t'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 20; i++) step("rw10", 1'b1, data_word_t'($urandom_range(0, 255)), 1'b1);
    check("count after rw", 32'(sb_q.size()), 32'd10);
    for (int i = 0; i < 11; i++) step("drain10", 1'b0, '0, 1'b1);

    // Full with a concurrent read: write is dropped, read still accepted.
    for (int i = 0; i < 128; i++) step("refill", 1'b1, data_word_t'(255 - i), 1'b0);
    step("full rw", 1'b1, 8'hBB, 1'b1);
    step("after full rw", 1'b0, '0, 1'b0);
    check("full rw word", 32'(rd_data), 32'hFF);

    // Reset mid-fill, then a single word round trip.
    do_reset("reset full");
    for (int i = 0; i < 60; i++) step("fill60", 1'b1, data_word_t'(i + 3), 1'b0);
    do_reset("reset mid");
    step("post-rst wr", 1'b1, 8'h55, 1'b0);
    step("post-rst rd", 1'b0, '0, 1'b1);
    step("post-rst tail", 1'b0, '0, 1'b0);
    check("post-rst word", 32'(rd_data), 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
